bcd_to_bin_seq: RTL and testbench

//  Iterative BCD-to-binary converter (reverse double-dabble), one shift per clock.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_sub3_adj.sv | 17 +
 rtl/bcd_to_bin_seq.sv | 110 +++++++++++
 tb/tb_bcd_to_bin_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the binary<->BCD conversion paths.
//   bcd_digit_t    one packed BCD digit
//   BCD_MAX_DIGIT  largest legal digit value
//   b2b_state_t    state encoding for the BCD-to-binary sequencer
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } b2b_state_t;

endpackage

// File: rtl/bcd_sub3_adj.sv
// Reverse double-dabble digit correction: after a right shift, a digit
// of 8 or more had a "ten" shifted into it, so subtract 3.
//   d  in   shifted BCD digit
//   q  out  corrected digit (d >= 8 ? d - 3 : d)
module bcd_sub3_adj
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  bcd_digit_t d_int;

  assign d_int = d;
  assign q     = (d_int >= 4'd8) ? d_int - 4'd3 : d_int;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter, one reverse double-dabble shift per clock.
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   bcd_in valid
//   in_ready   out  high only in IDLE
//   bcd_in     in   {digit[N-1],...,digit[0]}, 4 bits each
//   out_valid  out  high only in DONE
//   out_ready  in   downstream accepts result
//   bin_out    out  binary result, held while out_valid
//   err        out  some input digit was > 9 (qualified by out_valid)
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int unsigned NDIGITS = 3,
  parameter int unsigned BIN_W   = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NDIGITS-1:0] bcd_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIN_W-1:0]     bin_out,
  output logic                 err
);

  localparam int unsigned DW = 4 * NDIGITS;
  localparam int unsigned CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  b2b_state_t      state_q, state_d;
  logic [DW-1:0]   dig_q, dig_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [DW+BIN_W-1:0] shifted;
  logic [DW-1:0]       dig_adj;
  logic                bad_digit;

  // Digit 0's LSB drops into the bin MSB; the digit part is then corrected.
  assign shifted = {dig_q, bin_q} >> 1;

  for (genvar g = 0; g < NDIGITS; g++) begin : g_adj
    bcd_sub3_adj u_adj (
      .d (shifted[BIN_W + 4*g +: 4]),
      .q (dig_adj[4*g +: 4])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (bcd_in[4*i +: 4] > BCD_MAX_DIGIT) bad_digit = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    dig_d     = dig_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dig_d = bcd_in;
          bin_d = '0;
          cnt_d = CW'(BIN_W - 1);
          err_d = bad_digit;
          state_d = bad_digit ? DONE : CONVERT;
        end
      end
      CONVERT: begin
        dig_d = dig_adj;
        bin_d = shifted[BIN_W-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dig_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bin_out = bin_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq (NDIGITS=3, BIN_W=10).
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] bcd_in;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  bin_out;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_to_bin_seq #(.NDIGITS(3), .BIN_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err)
  );

  typedef struct {
    logic [11:0] bcd;
    logic [9:0]  bin;
    logic        err;
    int          lat;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // Accept one word and return the number of edges from the accepting edge
  // until out_valid is seen (sampled 1 time unit after each edge).
  task automatic run_conv(input logic [11:0] b, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    bcd_in   = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    bcd_in   = 12'hFFF;  // post-accept changes must not matter
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  vec_t vecs[9];

  initial begin
    int lat;
    int n;
    int seen;
    int t_prev, t_acc;
    int bad_val, bad_err, bad_gap, bad_dig;

    // normal conversions take BIN_W edges; bad digits reach DONE on the accepting edge
    vecs[0] = '{12'h255, 10'd255, 1'b0, 10};
    vecs[1] = '{12'h999, 10'd999, 1'b0, 10};
    vecs[2] = '{12'h000, 10'd0,   1'b0, 10};
    vecs[3] = '{12'h1A3, 10'd0,   1'b1, 0};
    vecs[4] = '{12'h042, 10'd42,  1'b0, 10};
    vecs[5] = '{12'h00F, 10'd0,   1'b1, 0};
    vecs[6] = '{12'hA00, 10'd0,   1'b1, 0};
    vecs[7] = '{12'h100, 10'd100, 1'b0, 10};
    vecs[8] = '{12'h909, 10'd909, 1'b0, 10};

    rst = 1'b1; in_valid = 1'b0; bcd_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_bin_out", int'(bin_out), 0);
    check("reset_err", int'(err), 0);
    rst = 1'b0;

    // table-driven vectors, out_ready held high
    for (int i = 0; i < 9; i++) begin
      run_conv(vecs[i].bcd, lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_bin", i), int'(bin_out), int'(vecs[i].bin));
      check($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].err));
      @(posedge clk); #1;
      check($sformatf("vec%0d_retired", i), int'(out_valid), 0);
    end

    // backpressure: result held while out_ready is low
    out_ready = 1'b0;
    run_conv(12'h371, lat);
    check("bp_latency", lat, 10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_valid", i), int'(out_valid), 1);
      check($sformatf("bp_hold%0d_bin", i), int'(bin_out), 371);
      check($sformatf("bp_hold%0d_in_ready", i), int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_retire_valid", int'(out_valid), 0);
    check("bp_retire_in_ready", int'(in_ready), 1);

    // reset in the middle of a conversion
    bcd_in = 12'h555; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_out_valid", seen, 0);
    run_conv(12'h042, lat);
    check("abort_next_latency", lat, 10);
    check("abort_next_bin", int'(bin_out), 42);
    @(posedge clk); #1;

    // exhaustive back-to-back, in_valid held high throughout
    bad_val = 0; bad_err = 0; bad_gap = 0; bad_dig = 0; t_prev = 0;
    in_valid = 1'b1;
    for (int v = 0; v < 1000; v++) begin
      bcd_in = to_bcd(v);
      n = 0;
      while (!in_ready && n < 50) begin
        @(posedge clk); #1; n++;
      end
      @(posedge clk); t_acc = cyc; #1;
      if (v > 0 && (t_acc - t_prev) != 12) bad_gap++;
      t_prev = t_acc;
      n = 0;
      while (!out_valid && n < 50) begin
        @(posedge clk); #1; n++;
      end
      if (!out_valid || bin_out != 10'(v)) bad_val++;
      if (err !== 1'b0) bad_err++;
      if (dut.dig_q !== 12'h000) bad_dig++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("exh_value_mismatches", bad_val, 0);
    check("exh_err_set", bad_err, 0);
    check("exh_spacing_not_12", bad_gap, 0);
    check("exh_digits_not_zero", bad_dig, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
